// File: rtl/spi_video_tx_pkg.sv
// Shared SPI video link definitions: FSM state encoding and default link geometry.
// Also used by the receiver side, so the defaults live here rather than in either block.
package spi_video_pkg;
    localparam int SPI_WORD_W  = 8;
    localparam int SPI_CLK_DIV = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_tx_state_e;
endpackage

// File: rtl/spi_video_tx_if.sv
// Word stream into the SPI transmitter: valid/ready handshake, a word moves when valid && ready.
// Master is the frame source, slave is spi_video_tx.
interface spi_video_tx_if
    import spi_video_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/spi_video_tx_clk_div.sv
// spi_tx_clk_div: SPI_clk generator, toggles every CLK_DIV enabled cycles; ticks flag the cycle before a toggle.
// Latency: one cycle from tick to SPI_clk edge; i_clear (or !i_en) forces counter and SPI_clk to 0 next cycle.
module spi_tx_clk_div
    import spi_video_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_term;

    assign w_term      = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise_tick = w_term && !r_sclk;
    assign o_fall_tick = w_term && r_sclk;
    assign o_sclk      = r_sclk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (i_clear || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_term) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_video_tx.sv
// spi_video_tx: word stream -> mode-0 SPI (MSB first) gated by synchronized chip_select; SPI_TX_PARITY_EN appends odd parity.
// First SPI_clk rise CLK_DIV cycles after accept; word_ready is held low while shifting except on the final falling tick.
module spi_video_tx
    import spi_video_pkg::*;
#(
    parameter int WORD_W  = SPI_WORD_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic                  i_CLK_40,
    input  logic                  i_reset,
    input  logic                  i_chip_select,
    spi_video_tx_if.slave         io_word,
    output logic                  o_SPI_clk,
    output logic                  o_MISO,
    output logic                  o_busy,
    output logic                  o_aborted
);
`ifdef SPI_TX_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    localparam int CNT_W = $clog2(FRAME_W);

    logic               r_cs_meta;
    logic               r_cs_sync;
    logic               w_cs_act;
    spi_tx_state_e      r_state;
    spi_tx_state_e      w_state_nxt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_load;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_aborted;
    logic               w_accept;
    logic               w_abort;
    logic               w_ready;
    logic               w_final;
    logic               w_fall;
    logic               w_rise_unused;

`ifdef SPI_TX_PARITY_EN
    assign w_load = {io_word.word_data, ~^io_word.word_data};
`else
    assign w_load = io_word.word_data;
`endif

    // Both flops reset to the inactive level so nothing starts until the receiver selects us.
    always_ff @(posedge i_CLK_40 or posedge i_reset) begin
        if (i_reset) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
        end else begin
            r_cs_meta <= i_chip_select;
            r_cs_sync <= r_cs_meta;
        end
    end
    assign w_cs_act = !r_cs_sync;

    spi_tx_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .i_clk       (i_CLK_40),
        .i_rst       (i_reset),
        .i_en        (r_state == SHIFT),
        .i_clear     (w_accept || w_abort),
        .o_sclk      (o_SPI_clk),
        .o_rise_tick (w_rise_unused),
        .o_fall_tick (w_fall)
    );

    assign w_final = w_fall && (r_bit_cnt == '0);

    always_ff @(posedge i_CLK_40 or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Abort is checked before the final tick so a deselect on the last edge never accepts.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = w_cs_act;
                if (w_cs_act && io_word.word_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_cs_act) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_final) begin
                    w_ready = 1'b1;
                    if (io_word.word_valid) w_accept    = 1'b1;
                    else                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_word.word_ready = w_ready;

    always_ff @(posedge i_CLK_40 or posedge i_reset) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
            if (w_accept) begin
                r_shift   <= w_load;
                r_bit_cnt <= CNT_W'(FRAME_W - 1);
            end else if (w_abort) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if ((r_state == SHIFT) && w_fall) begin
                if (r_bit_cnt != '0) begin
                    r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                end else begin
                    r_shift   <= '0;
                end
            end
        end
    end

    assign o_MISO    = r_shift[FRAME_W-1];
    assign o_busy    = (r_state == SHIFT);
    assign o_aborted = r_aborted;
endmodule

// File: doc/spi_video_tx.md
# spi_video_tx

SPI transmit end of the video data link: serializes words from a local valid/ready stream onto `SPI_clk`/`MISO` for the data translator receiver, gated by the `chip_select` that the receiver drives. The block runs entirely in the `CLK_40` domain, generates `SPI_clk` by division, and synchronizes the incoming `chip_select` internally. It sits between the frame source (ROM/FIFO reader) and the GPIO pins.

## Interface
- `WORD_W`, 8: bits per word, ≥ 2.
- `CLK_DIV`, 4: `CLK_40` cycles per `SPI_clk` half-period, ≥ 1. Default gives a 5 MHz SPI clock.
---
- `CLK_40`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `chip_select`, in, 1: from the receiver, active-low, asynchronous to `CLK_40`.
- `word_data`, in, WORD_W: word to send, MSB first.
- `word_valid`, in, 1: `word_data` is valid.
- `word_ready`, out, 1: a word is accepted on a cycle where `word_valid && word_ready`.
- `SPI_clk`, out, 1: serial clock, idles low (mode 0).
- `MISO`, out, 1: serial data.
- `busy`, out, 1: a word is in flight.
- `aborted`, out, 1: one-cycle pulse when a word is dropped because `chip_select` deasserted.

## Operation
- `chip_select` passes through a local 2-flop synchronizer. Both flops reset to 1 (inactive). `cs_act` = synchronized value == 0.
- States:
  - IDLE: `SPI_clk`=0, `MISO`=0, `busy`=0.
  - SHIFT: `busy`=1.
- `word_ready` is combinational:
  - IDLE: equals `cs_act`.
  - SHIFT: equals `cs_act` only on the final falling-edge tick.
  - All other cycles: 0.
- Accept (IDLE→SHIFT, or SHIFT→SHIFT on the final tick):
  - Load the shift register.
  - `bit_cnt` = FRAME_W−1, where FRAME_W = WORD_W, or WORD_W+1 with parity.
  - `MISO` = word MSB on the next cycle.
  - Divider cleared; `SPI_clk` stays 0.
- SHIFT:
  - Divider counts 0..CLK_DIV−1. At the terminal count, `SPI_clk` toggles.
  - Rising toggle: no data change. The receiver samples here.
  - Falling toggle with `bit_cnt`≠0: shift left, decrement `bit_cnt`, present the next bit on `MISO` in the same cycle as `SPI_clk` falls.
  - Falling toggle with `bit_cnt`==0 (final tick): take a new word if accepted, else go to IDLE with `MISO`=0.
- Abort: if `cs_act`==0 in SHIFT, go to IDLE on the next cycle.
  - `SPI_clk`=0 and `MISO`=0 that cycle.
  - `aborted`=1 for exactly that cycle.
  - The partial word is discarded, never resent.
- Simultaneous abort and final tick: abort wins. No accept occurs, and `aborted` pulses.
- `word_valid` with `cs_act`==0: held off. No `SPI_clk` activity.

## Timing
- Reset values: `SPI_clk`=0, `MISO`=0, `word_ready`=0, `busy`=0, `aborted`=0, state IDLE, counters 0.
- `chip_select` falling → `word_ready` high: 2–3 `CLK_40` cycles (synchronizer latency).
- Accept cycle → first `SPI_clk` rising: CLK_DIV cycles.
- Bit period: 2·CLK_DIV cycles. Frame: FRAME_W·2·CLK_DIV cycles from accept to final falling edge.
- Back-to-back words: no gap. The `SPI_clk` period stays uniform across word boundaries.
- `MISO` is stable for the full CLK_DIV cycles before and after every rising edge.
- `chip_select` deassert → `SPI_clk` forced low: ≤ 3 cycles (sync + 1).

## Configuration
- Macro: `SPI_TX_PARITY_EN`.
- Defined: one odd-parity bit, `~^word`, is sent after the LSB, and FRAME_W = WORD_W+1.
- Undefined: FRAME_W = WORD_W, and no parity logic is present.

## Structure
- Shared package `spi_video_pkg`:
  - `spi_tx_state_e` enum (IDLE, SHIFT).
  - Default constants `SPI_WORD_W`=8 and `SPI_CLK_DIV`=4, also used by the receiver.
- Sub-module `spi_tx_clk_div`: divider counter plus `SPI_clk` register. Outputs `rise_tick`/`fall_tick` and takes a `clear` input.
- Parent holds the synchronizer, FSM, shift register and `bit_cnt`.

## Test plan
- WORD_W=8, CLK_DIV=2, `chip_select`=0, send 0xA5:
  - `MISO` at `SPI_clk` rising edges = 1,0,1,0,0,1,0,1.
  - Edges 4 cycles apart.
  - `busy` high for 32 cycles, then `SPI_clk`=0 and `MISO`=0.
- 0x3C then 0xC3 with `word_valid` held:
  - 16 rising edges at an unbroken 4-cycle period.
  - Bits 00111100 11000011.
  - `word_ready` pulses exactly twice.
- `chip_select`=1 with `word_valid`=1 for 50 cycles → `word_ready`=0 and `SPI_clk` static 0. Drop `chip_select` → accept within 3 cycles.
- Raise `chip_select` after the 3rd rising edge of 0xFF:
  - `aborted` is a 1-cycle pulse within 3 cycles.
  - `SPI_clk`=0 and `busy`=0.
  - The next word starts fresh at its MSB.
- `SPI_TX_PARITY_EN` defined:
  - 0x00 → 9 bits, 9th bit = 1.
  - 0x01 → 9th bit = 0.
  - Frame is 36 cycles.
- Assert `reset` mid-word (bit 4): all outputs 0 asynchronously, and the first word after release starts at the MSB.
